// File: rtl/irq_controller.sv
// Z80 mode-2 interrupt controller: latches edge requests, arbitrates with nested priority,
// drives int_n and answers the interrupt-acknowledge cycle with an IM2 vector byte.
module irq_controller #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter logic [7:0]  SPURIOUS_VEC = 8'hFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic               wr_n,
  input  logic [2:0]         reg_addr_i,
  input  logic [7:0]         data_i,
  input  logic               intc_cs,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [7:0]         data_o,
  output logic               ack_o,
  output logic               int_n
);

  typedef enum logic [1:0] {StIdle, StAck, StDone} state_e;

  localparam logic [2:0] AddrMask      = 3'd0;
  localparam logic [2:0] AddrPending   = 3'd1;
  localparam logic [2:0] AddrVecbase   = 3'd2;
  localparam logic [2:0] AddrInservice = 3'd3;
  localparam logic [2:0] AddrEoi       = 3'd4;
  localparam logic [2:0] AddrCtrl      = 3'd5;

  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q, irq_prev_q, irq_edge;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] inservice_q, inservice_d;
  logic [3:0]         vecbase_q, vecbase_d;
  logic               ctrl_q, ctrl_d;

  logic               wr_term, wr_term_q, wr_commit;
  logic [NUM_IRQ-1:0] allowed, eligible, eoi_clr;
  logic [2:0]         winner;
  logic               any_eligible;

  state_e             state_q, state_d;
  logic [7:0]         vec_q, vec_d;
  logic               hit_q, hit_d;
  logic [2:0]         win_q, win_d;
  logic               ack_done;
  logic               int_n_q;
  logic [7:0]         rd_data;

  // Input synchronisers and edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_prev_q <= '0;
    end else begin
      irq_s1_q   <= irq_i;
      irq_s2_q   <= irq_s1_q;
      irq_prev_q <= irq_s2_q;
    end
  end

  assign irq_edge = irq_s2_q & ~irq_prev_q;

  // One commit per bus cycle, however long the strobe is held
  assign wr_term   = intc_cs & ~wr_n & ~iorq_n;
  assign wr_commit = wr_term & ~wr_term_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_term_q <= 1'b0;
    end else begin
      wr_term_q <= wr_term;
    end
  end

  // A source is allowed only if no equal-or-higher priority source is in service
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    allowed = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blocked    = blocked | inservice_q[i];
      allowed[i] = ~blocked;
    end
  end

  assign eligible     = pending_q & mask_q & allowed;
  assign any_eligible = |eligible;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 3'(i);
      end
    end
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    eoi_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (inservice_q[i] && !found) begin
        eoi_clr[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Register next state: clears first, new edges last so a coincident set wins
  always_comb begin
    mask_d      = mask_q;
    pending_d   = pending_q;
    inservice_d = inservice_q;
    vecbase_d   = vecbase_q;
    ctrl_d      = ctrl_q;

    if (wr_commit) begin
      case (reg_addr_i)
        AddrMask:    mask_d      = data_i[NUM_IRQ-1:0];
        AddrPending: pending_d   = pending_q & ~data_i[NUM_IRQ-1:0];
        AddrVecbase: vecbase_d   = data_i[7:4];
        AddrEoi:     inservice_d = inservice_q & ~eoi_clr;
        AddrCtrl:    ctrl_d      = data_i[0];
        default: ;
      endcase
    end

    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_done && hit_q && (win_q == 3'(i))) begin
        pending_d[i]   = 1'b0;
        inservice_d[i] = 1'b1;
      end
    end

    pending_d = pending_d | irq_edge;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q      <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      vecbase_q   <= '0;
      ctrl_q      <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      vecbase_q   <= vecbase_d;
      ctrl_q      <= ctrl_d;
      int_n_q     <= ~(ctrl_q & any_eligible);
    end
  end

  assign int_n = int_n_q;

  // Acknowledge sequencer; vector is frozen at entry to StAck
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hit_d    = hit_q;
    win_d    = win_q;
    ack_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (!m1_n && !iorq_n) begin
          state_d = StAck;
          hit_d   = any_eligible;
          win_d   = winner;
          vec_d   = any_eligible ? {vecbase_q, winner, 1'b0} : SPURIOUS_VEC;
        end
      end
      StAck: begin
        if (m1_n || iorq_n) begin
          state_d  = StDone;
          ack_done = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vec_q   <= '0;
      hit_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hit_q   <= hit_d;
      win_q   <= win_d;
    end
  end

  assign ack_o = (state_q == StAck);

  always_comb begin
    rd_data = '0;
    case (reg_addr_i)
      AddrMask:      rd_data[NUM_IRQ-1:0] = mask_q;
      AddrPending:   rd_data[NUM_IRQ-1:0] = pending_q;
      AddrVecbase:   rd_data              = {vecbase_q, 4'h0};
      AddrInservice: rd_data[NUM_IRQ-1:0] = inservice_q;
      AddrCtrl:      rd_data[0]           = ctrl_q;
      default: ;
    endcase
  end

  always_comb begin
    data_o = '0;
    if (ack_o) begin
      data_o = vec_q;
    end else if (intc_cs) begin
      data_o = rd_data;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expectations, a negedge monitor
// compares register reads, int_n/ack_o samples and acknowledge vectors.
module tb_irq_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       m1_n = 1'b1;
  logic       iorq_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [2:0] reg_addr_i = '0;
  logic [7:0] data_i = '0;
  logic       intc_cs = 1'b0;
  logic [7:0] irq_i = '0;
  logic [7:0] data_o;
  logic       ack_o;
  logic       int_n;

  irq_controller #(
    .NUM_IRQ     (8),
    .SPURIOUS_VEC(8'hFF)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m1_n      (m1_n),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .reg_addr_i(reg_addr_i),
    .data_i    (data_i),
    .intc_cs   (intc_cs),
    .irq_i     (irq_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .int_n     (int_n)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    int         kind;  // 0 data_o read, 1 int_n, 2 ack_o
    logic [7:0] val;
  } exp_t;

  exp_t       chk_q[$];
  logic [7:0] ack_q[$];
  logic       chk_req = 1'b0;
  logic       ack_prev = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk_i) begin
    if (chk_req) begin
      tests++;
      if (chk_q.size() == 0) begin
        fails++;
        $display("FAIL chk_underflow: got no expectation, required one queued");
      end else begin
        exp_t       e;
        logic [7:0] act;
        e = chk_q.pop_front();
        case (e.kind)
          1:       act = {7'b0, int_n};
          2:       act = {7'b0, ack_o};
          default: act = data_o;
        endcase
        if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got 0x%02h, required 0x%02h", e.name, act, e.val);
        end
      end
    end
    if (ack_o && !ack_prev) begin
      tests++;
      if (ack_q.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected: got vector 0x%02h, required no ack", data_o);
      end else begin
        logic [7:0] ev;
        ev = ack_q.pop_front();
        if (data_o !== ev) begin
          fails++;
          $display("FAIL ack_vector: got 0x%02h, required 0x%02h", data_o, ev);
        end
      end
    end
    ack_prev = ack_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_reg(input logic [2:0] addr, input logic [7:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.kind = 0;
    e.val  = exp;
    chk_q.push_back(e);
    intc_cs    = 1'b1;
    reg_addr_i = addr;
    chk_req    = 1'b1;
    tick(1);
    chk_req = 1'b0;
    intc_cs = 1'b0;
  endtask

  task automatic check_sig(input int kind, input logic exp, input string name);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = {7'b0, exp};
    chk_q.push_back(e);
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [7:0] val);
    intc_cs    = 1'b1;
    reg_addr_i = addr;
    data_i     = val;
    iorq_n     = 1'b0;
    wr_n       = 1'b0;
    tick(1);
    wr_n    = 1'b1;
    iorq_n  = 1'b1;
    intc_cs = 1'b0;
    tick(1);
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq_i = irq_i | bits;
    tick(2);
    irq_i = irq_i & ~bits;
    tick(3);
  endtask

  task automatic do_ack(input logic [7:0] exp_vec);
    ack_q.push_back(exp_vec);
    m1_n = 1'b0;
    tick(1);
    iorq_n = 1'b0;
    tick(3);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    rst_i = 1'b0;
    tick(1);

    // Reset state
    check_sig(1, 1'b1, "rst_int_n");
    check_sig(2, 1'b0, "rst_ack_o");
    check_reg(3'd0, 8'h00, "rst_mask");
    check_reg(3'd1, 8'h00, "rst_pending");

    // Basic IM2
    bus_write(3'd0, 8'h04);
    bus_write(3'd2, 8'h8F);
    bus_write(3'd5, 8'h01);
    check_reg(3'd2, 8'h80, "vecbase_low_zero");
    check_reg(3'd5, 8'h01, "ctrl_read");
    bus_write(3'd6, 8'hFF);
    check_reg(3'd6, 8'h00, "reg6_reads_zero");
    pulse(8'h04);
    check_sig(1, 1'b0, "basic_int_low");
    do_ack(8'h84);
    check_reg(3'd1, 8'h00, "basic_pending_cleared");
    check_reg(3'd3, 8'h04, "basic_inservice");
    check_sig(1, 1'b1, "basic_int_high");
    bus_write(3'd4, 8'h00);
    check_reg(3'd3, 8'h00, "basic_eoi");

    // Priority and nesting
    bus_write(3'd0, 8'hFF);
    pulse(8'h22);
    check_reg(3'd1, 8'h22, "prio_pending");
    do_ack(8'h82);
    check_reg(3'd3, 8'h02, "prio_inservice1");
    pulse(8'h08);
    check_sig(1, 1'b1, "nest_blocks_bit3");
    bus_write(3'd4, 8'h00);
    tick(1);
    check_sig(1, 1'b0, "nest_after_eoi");
    do_ack(8'h86);
    check_sig(1, 1'b1, "nest_blocks_bit5");
    bus_write(3'd4, 8'h00);
    do_ack(8'h8A);
    check_reg(3'd3, 8'h20, "prio_inservice5");
    bus_write(3'd4, 8'h00);
    check_reg(3'd1, 8'h00, "prio_pending_empty");

    // Masking and W1C
    bus_write(3'd0, 8'h00);
    pulse(8'h40);
    check_reg(3'd1, 8'h40, "mask_pending");
    check_sig(1, 1'b1, "masked_int_high");
    bus_write(3'd0, 8'h40);
    check_sig(1, 1'b0, "unmasked_int_low");
    bus_write(3'd1, 8'h40);
    check_sig(1, 1'b1, "w1c_int_high");
    check_reg(3'd1, 8'h00, "w1c_pending");

    // Spurious ack and level input
    do_ack(8'hFF);
    check_reg(3'd1, 8'h00, "spur_pending");
    check_reg(3'd3, 8'h00, "spur_inservice");
    check_reg(3'd0, 8'h40, "spur_mask");
    bus_write(3'd0, 8'h00);
    irq_i[0] = 1'b1;
    tick(100);
    check_reg(3'd1, 8'h01, "level_single_set");
    bus_write(3'd1, 8'h01);
    tick(5);
    check_reg(3'd1, 8'h00, "level_no_retrigger");
    irq_i[0] = 1'b0;
    tick(3);

    // Held write strobe on EOI commits once
    bus_write(3'd0, 8'h06);
    pulse(8'h04);
    do_ack(8'h84);
    pulse(8'h02);
    do_ack(8'h82);
    check_reg(3'd3, 8'h06, "hold_inservice_pre");
    intc_cs    = 1'b1;
    reg_addr_i = 3'd4;
    iorq_n     = 1'b0;
    wr_n       = 1'b0;
    tick(5);
    wr_n    = 1'b1;
    iorq_n  = 1'b0;
    iorq_n  = 1'b1;
    intc_cs = 1'b0;
    tick(1);
    check_reg(3'd3, 8'h04, "hold_single_commit");
    bus_write(3'd4, 8'h00);

    // Edge coincident with W1C of the same bit: set wins
    pulse(8'h04);
    irq_i[2] = 1'b1;
    tick(2);
    bus_write(3'd1, 8'h04);
    irq_i[2] = 1'b0;
    tick(2);
    check_reg(3'd1, 8'h04, "collision_set_wins");

    // Reset mid-acknowledge
    ack_q.push_back(8'h84);
    m1_n = 1'b0;
    tick(1);
    iorq_n = 1'b0;
    tick(2);
    rst_i = 1'b1;
    check_sig(2, 1'b0, "reset_ack_async");
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick(1);
    check_sig(1, 1'b1, "reset_int_n");
    for (int a = 0; a < 6; a++) begin
      check_reg(3'(a), 8'h00, "reset_reg_zero");
    end

    tick(3);
    tests++;
    if (ack_q.size() != 0 || chk_q.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: got %0d/%0d left, required 0/0", ack_q.size(),
               chk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
